// File: rtl/sink_serializer.sv
// Serializes PKT_WIDTH-bit sink packets into BYTE_WIDTH-bit words, MSB first.
// A one-packet hold register lets the next packet wait so words can go out back-to-back.
module sink_serializer #(
    parameter int PKT_WIDTH  = 8,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [PKT_WIDTH-1:0]  snk,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           pkt_count
);

    localparam int NUM_BYTES = (PKT_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int PAD_WIDTH = NUM_BYTES * BYTE_WIDTH;
    localparam int CNT_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [PAD_WIDTH-1:0]   shift_reg, shift_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [PKT_WIDTH-1:0]   hold_reg, hold_next;
    logic                   hold_full_reg, hold_full_next;
    logic [15:0]            pkt_count_reg, pkt_count_next;

    logic [PAD_WIDTH-1:0]   snk_aligned;
    logic [PAD_WIDTH-1:0]   hold_aligned;
    logic                   pkt_hs;
    logic                   word_hs;
    logic                   final_word;

    // Packets sit MSB-aligned in the shift register; the low pad bits are zero.
    generate
        if (PAD_WIDTH == PKT_WIDTH) begin : g_no_pad
            assign snk_aligned  = snk;
            assign hold_aligned = hold_reg;
        end else begin : g_pad
            assign snk_aligned  = {snk, {(PAD_WIDTH - PKT_WIDTH){1'b0}}};
            assign hold_aligned = {hold_reg, {(PAD_WIDTH - PKT_WIDTH){1'b0}}};
        end
    endgenerate

    assign snk_ready  = !hold_full_reg;
    assign out_valid  = (state_reg == SEND);
    assign out_data   = shift_reg[PAD_WIDTH-1 -: BYTE_WIDTH];
    assign pkt_count  = pkt_count_reg;

    assign pkt_hs     = snk_valid && snk_ready;
    assign word_hs    = out_valid && out_ready;
    assign final_word = word_hs && (cnt_reg == LAST_CNT);

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        pkt_count_next = pkt_count_reg;

        case (state_reg)
            IDLE: begin
                if (pkt_hs) begin
                    shift_next = snk_aligned;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (final_word) begin
                    pkt_count_next = pkt_count_reg + 16'd1;
                    cnt_next       = '0;
                    // Refill straight from hold or the sink so the next word follows without a gap.
                    if (hold_full_reg) begin
                        shift_next     = hold_aligned;
                        hold_full_next = 1'b0;
                    end else if (pkt_hs) begin
                        shift_next = snk_aligned;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (word_hs) begin
                        shift_next = shift_reg << BYTE_WIDTH;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                    if (pkt_hs) begin
                        hold_next      = snk;
                        hold_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            pkt_count_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            pkt_count_reg <= pkt_count_next;
        end
    end

endmodule

// File: tb/tb_sink_serializer.sv
// Bench for sink_serializer: a 12-bit/8-bit instance (two words per packet)
// and an 8-bit/8-bit instance (one word per packet, counter wrap).
module tb_sink_serializer;

    logic        clk;
    logic        arstn;

    logic [11:0] snk1;
    logic        snk_valid1, snk_ready1;
    logic [7:0]  out_data1;
    logic        out_valid1, out_ready1;
    logic [15:0] pkt_count1;

    logic [7:0]  snk2;
    logic        snk_valid2, snk_ready2;
    logic [7:0]  out_data2;
    logic        out_valid2, out_ready2;
    logic [15:0] pkt_count2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt1 = 0;
    int exp_cnt2 = 0;

    sink_serializer #(.PKT_WIDTH(12), .BYTE_WIDTH(8)) dut1 (
        .clk(clk), .arstn(arstn),
        .snk(snk1), .snk_valid(snk_valid1), .snk_ready(snk_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .pkt_count(pkt_count1)
    );

    sink_serializer #(.PKT_WIDTH(8), .BYTE_WIDTH(8)) dut2 (
        .clk(clk), .arstn(arstn),
        .snk(snk2), .snk_valid(snk_valid2), .snk_ready(snk_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .pkt_count(pkt_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] pkt;
        logic [7:0]  w0;
        logic [7:0]  w1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One isolated packet on dut1 with the transport always ready.
    task automatic send1(input logic [11:0] p, input logic [7:0] w0, input logic [7:0] w1, input string tag);
        @(negedge clk);
        snk1 = p; snk_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        snk_valid1 = 1'b0;
        check({tag, ".valid0"}, 32'(out_valid1), 32'd1);
        check({tag, ".w0"}, 32'(out_data1), 32'(w0));
        @(negedge clk);
        check({tag, ".w1"}, 32'(out_data1), 32'(w1));
        @(negedge clk);
        exp_cnt1++;
        check({tag, ".idle"}, 32'(out_valid1), 32'd0);
        check({tag, ".count"}, 32'(pkt_count1), 32'(exp_cnt1 % 65536));
        $display("%s: pkt %h -> words %h %h", tag, p, w0, w1);
    endtask

    task automatic drain2(input string tag);
        int t;
        t = 0;
        while (out_valid2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, ".drain"}, 32'(out_valid2), 32'd0);
    endtask

    initial begin
        bit [7:0] wq [$];
        int words_done;
        int inflight;
        bit m_valid, m_ready, feed;
        int accepted, cyc, target;

        vecs[0] = '{12'hABC, 8'hAB, 8'hC0};
        vecs[1] = '{12'h000, 8'h00, 8'h00};
        vecs[2] = '{12'hFFF, 8'hFF, 8'hF0};
        vecs[3] = '{12'h5A5, 8'h5A, 8'h50};
        vecs[4] = '{12'h801, 8'h80, 8'h10};
        vecs[5] = '{12'h3C7, 8'h3C, 8'h70};

        arstn = 1'b0;
        snk1 = '0; snk_valid1 = 1'b0; out_ready1 = 1'b0;
        snk2 = '0; snk_valid2 = 1'b0; out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.out_valid", 32'(out_valid1), 32'd0);
        check("reset.snk_ready", 32'(snk_ready1), 32'd1);
        check("reset.pkt_count", 32'(pkt_count1), 32'd0);
        arstn = 1'b1;

        // Table of single packets.
        for (int i = 0; i < 6; i++)
            send1(vecs[i].pkt, vecs[i].w0, vecs[i].w1, $sformatf("vec%0d", i));

        // Back-to-back: second packet goes to hold during the first word.
        @(negedge clk);
        snk1 = 12'h123; snk_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        snk1 = 12'h456;
        check("b2b.w0", 32'(out_data1), 32'h12);
        check("b2b.ready0", 32'(snk_ready1), 32'd1);
        @(negedge clk);
        snk_valid1 = 1'b0;
        check("b2b.w1", 32'(out_data1), 32'h30);
        check("b2b.ready1", 32'(snk_ready1), 32'd0);
        @(negedge clk);
        check("b2b.w2", 32'(out_data1), 32'h45);
        check("b2b.valid2", 32'(out_valid1), 32'd1);
        check("b2b.ready2", 32'(snk_ready1), 32'd1);
        @(negedge clk);
        check("b2b.w3", 32'(out_data1), 32'h60);
        @(negedge clk);
        exp_cnt1 += 2;
        check("b2b.idle", 32'(out_valid1), 32'd0);
        check("b2b.count", 32'(pkt_count1), 32'(exp_cnt1));
        $display("b2b: pkts 123 456 -> words 12 30 45 60");

        // Backpressure on the first word while a second packet waits in hold.
        @(negedge clk);
        snk1 = 12'hABC; snk_valid1 = 1'b1; out_ready1 = 1'b0;
        @(negedge clk);
        snk1 = 12'hDEF;
        check("bp.first", 32'(out_data1), 32'hAB);
        check("bp.ready_first", 32'(snk_ready1), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            snk_valid1 = 1'b0;
            check($sformatf("bp.stall%0d.data", k), 32'(out_data1), 32'hAB);
            check($sformatf("bp.stall%0d.valid", k), 32'(out_valid1), 32'd1);
            check($sformatf("bp.stall%0d.ready", k), 32'(snk_ready1), 32'd0);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        check("bp.w1", 32'(out_data1), 32'hC0);
        check("bp.ready_w1", 32'(snk_ready1), 32'd0);
        @(negedge clk);
        check("bp.w2", 32'(out_data1), 32'hDE);
        check("bp.ready_w2", 32'(snk_ready1), 32'd1);
        @(negedge clk);
        check("bp.w3", 32'(out_data1), 32'hF0);
        @(negedge clk);
        exp_cnt1 += 2;
        check("bp.idle", 32'(out_valid1), 32'd0);
        check("bp.count", 32'(pkt_count1), 32'(exp_cnt1));
        $display("bp: pkts ABC DEF with 5-cycle stall on first word");

        // Randomized traffic against a word-queue model.
        words_done = 0;
        for (int c = 0; c < 600; c++) begin
            feed = (c < 580);
            @(negedge clk);
            inflight = (wq.size() + 1) / 2;
            m_valid  = (wq.size() > 0);
            m_ready  = (inflight < 2);
            check("rand.out_valid", 32'(out_valid1), 32'(m_valid));
            check("rand.snk_ready", 32'(snk_ready1), 32'(m_ready));
            check("rand.pkt_count", 32'(pkt_count1), 32'(exp_cnt1 % 65536));
            if (m_valid)
                check("rand.out_data", 32'(out_data1), 32'(wq[0]));
            snk1       = 12'($urandom);
            snk_valid1 = feed && ($urandom_range(3) != 0);
            out_ready1 = !feed || ($urandom_range(3) != 0);
            @(posedge clk);
            if (m_valid && out_ready1) begin
                void'(wq.pop_front());
                words_done++;
                if (words_done % 2 == 0)
                    exp_cnt1++;
            end
            if (snk_valid1 && m_ready) begin
                wq.push_back(snk1[11:4]);
                wq.push_back({snk1[3:0], 4'h0});
                $display("rand: cycle %0d accepted pkt %h", c, snk1);
            end
        end
        @(negedge clk);
        snk_valid1 = 1'b0;
        check("rand.drained", 32'(wq.size()), 32'd0);
        check("rand.final_count", 32'(pkt_count1), 32'(exp_cnt1 % 65536));

        // Reset while the second word of ABC is pending and DEF is held.
        @(negedge clk);
        snk1 = 12'hABC; snk_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        snk1 = 12'hDEF;
        check("rst.w0", 32'(out_data1), 32'hAB);
        @(negedge clk);
        snk_valid1 = 1'b0;
        check("rst.hold_full", 32'(snk_ready1), 32'd0);
        arstn = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid1), 32'd0);
        check("rst.snk_ready", 32'(snk_ready1), 32'd1);
        check("rst.pkt_count", 32'(pkt_count1), 32'd0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        exp_cnt1 = 0;
        send1(12'h5A5, 8'h5A, 8'h50, "rst.after");
        $display("rst: mid-packet reset discarded ABC and DEF");

        // One-word packets: a final word with a simultaneous handshake loads without an idle cycle.
        @(negedge clk);
        snk2 = 8'h11; snk_valid2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk);
        snk2 = 8'h22;
        check("one.w0", 32'(out_data2), 32'h11);
        check("one.ready0", 32'(snk_ready2), 32'd1);
        @(negedge clk);
        snk2 = 8'h33;
        check("one.w1", 32'(out_data2), 32'h22);
        check("one.valid1", 32'(out_valid2), 32'd1);
        @(negedge clk);
        snk_valid2 = 1'b0;
        check("one.w2", 32'(out_data2), 32'h33);
        check("one.valid2", 32'(out_valid2), 32'd1);
        @(negedge clk);
        exp_cnt2 = 3;
        check("one.idle", 32'(out_valid2), 32'd0);
        check("one.count", 32'(pkt_count2), 32'(exp_cnt2));
        $display("one: pkts 11 22 33 -> one word each, no gaps");

        // Stream packets up to a count of 0xFFFF, then one more to wrap.
        target = 65535 - exp_cnt2;
        accepted = 0;
        cyc = 0;
        while (accepted < target && cyc < 70000) begin
            snk2 = 8'($urandom);
            snk_valid2 = 1'b1;
            if (snk_ready2)
                accepted++;
            @(negedge clk);
            cyc++;
        end
        snk_valid2 = 1'b0;
        check("wrap.accepted", 32'(accepted), 32'(target));
        drain2("wrap.pre");
        exp_cnt2 = (exp_cnt2 + accepted) % 65536;
        check("wrap.max", 32'(pkt_count2), 32'(exp_cnt2));
        $display("wrap: %0d packets streamed, count now %h", accepted, pkt_count2);
        snk2 = 8'hE7; snk_valid2 = 1'b1;
        @(negedge clk);
        snk_valid2 = 1'b0;
        check("wrap.last_word", 32'(out_data2), 32'hE7);
        drain2("wrap.post");
        exp_cnt2 = (exp_cnt2 + 1) % 65536;
        check("wrap.zero", 32'(pkt_count2), 32'(exp_cnt2));
        $display("wrap: one more packet, count now %h", pkt_count2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sink_serializer.md
SINK_SERIALIZER -- requirements
Module: sink_serializer

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 8: width of one sink packet in bits, minimum 1.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8: output word width in bits.
REQ-003 SHALL derive NUM_BYTES = ceil(PKT_WIDTH/BYTE_WIDTH) and PAD_WIDTH = NUM_BYTES*BYTE_WIDTH.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port arstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port snk, input, PKT_WIDTH, packet from the network sink.
REQ-007 SHALL have port snk_valid, input, 1, snk holds a packet.
REQ-008 SHALL have port snk_ready, output, 1, block can accept a packet.
REQ-009 SHALL have port out_data, output, BYTE_WIDTH, serialized word to the transport.
REQ-010 SHALL have port out_valid, output, 1, out_data is valid.
REQ-011 SHALL have port out_ready, input, 1, transport accepts out_data.
REQ-012 SHALL have port pkt_count, output, 16, count of fully transmitted packets.

Function
REQ-013 SHALL define the packet handshake as snk_valid && snk_ready in the same cycle, and the word handshake as out_valid && out_ready.
REQ-014 SHALL hold a shift register (PAD_WIDTH), a word counter (0..NUM_BYTES-1), a hold register (PKT_WIDTH) with flag hold_full, and a 2-state FSM: IDLE, SEND.
REQ-015 SHALL drive snk_ready = !hold_full combinationally; it depends on no other signal.
REQ-016 SHALL load the packet MSB-aligned into the shift register: shift = {packet, zeros(PAD_WIDTH-PKT_WIDTH)}.
REQ-017 SHALL drive out_data = shift[PAD_WIDTH-1 -: BYTE_WIDTH] and out_valid = (state == SEND).
REQ-018 SHALL, in IDLE on a packet handshake, load shift from snk, clear the counter and enter SEND; the first word is valid on the next cycle.
REQ-019 SHALL, in SEND on a non-final word handshake, shift left by BYTE_WIDTH and increment the counter.
REQ-020 SHALL treat a word handshake with counter == NUM_BYTES-1 as final; on it, pkt_count increments, wrapping 0xFFFF to 0.
REQ-021 SHALL, on a final word: if hold_full, load shift from hold, clear hold_full and the counter, and stay in SEND.
REQ-022 SHALL, on a final word with hold empty and a simultaneous packet handshake, load shift from snk directly, clear the counter and stay in SEND.
REQ-023 SHALL, on a final word with hold empty and no packet handshake, return to IDLE.
REQ-024 SHALL, in SEND on a packet handshake not coinciding with a final word, write snk to hold and set hold_full.
REQ-025 SHALL keep out_data, the counter and shift stable while out_valid && !out_ready.
REQ-026 SHALL sustain one word per cycle across packet boundaries with no bubble when packets are available.
REQ-027 SHALL, when NUM_BYTES == 1, treat every word handshake as final.
REQ-028 SHALL never drop, duplicate or reorder packets; at most 2 packets are in flight, one in shift and one in hold.

Reset
REQ-029 SHALL, while arstn is low, force state IDLE, shift 0, counter 0, hold 0, hold_full 0 and pkt_count 0; hence out_valid 0 and snk_ready 1.
REQ-030 SHALL, when arstn is asserted mid-packet, discard the partial packet and any held packet; the first packet after release starts at word 0.

Verification
REQ-031 Single packet: PKT_WIDTH=12, snk=0xABC, out_ready=1 -> out_data 0xAB then 0xC0 on consecutive cycles, then out_valid=0, pkt_count=1.
REQ-032 Back-to-back: PKT_WIDTH=12, snk_valid held high with 0x123 then 0x456, out_ready=1 -> words 0x12,0x30,0x45,0x60 with no gaps; snk_ready drops only while hold is full.
REQ-033 Backpressure: out_ready=0 for 5 cycles during the first word -> out_data stays 0xAB, out_valid=1; second packet lands in hold; snk_ready=0 afterward until the current packet's final word.
REQ-034 Boundary: PKT_WIDTH=8 -> each packet yields exactly 1 word; a final word coinciding with a new packet handshake loads the new packet with no IDLE cycle.
REQ-035 Reset mid-operation: arstn low after the first word of 0xABC with hold full -> out_valid=0, snk_ready=1, pkt_count=0; after release, packet 0x5A5 yields 0x5A,0x50 only.
REQ-036 Wrap: force 65536 packets (or preload via a bench hook) -> pkt_count wraps from 0xFFFF to 0x0000.
